axi_deny_responder: RTL and testbench

AXI_DENY_RESPONDER -- requirements
Module: axi_deny_responder

---
 rtl/axi_deny_responder_pkg.sv | 32 +++
 rtl/axi_deny_responder_if.sv | 52 +++++
 rtl/axi_deny_responder.sv | 152 +++++++++++++++
 tb/tb_axi_deny_responder.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_deny_responder_pkg.sv
// Shared protection-unit definitions: AXI response codes, deny-responder FSM
// states and the saturating violation-counter helper.
package axi_deny_responder_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int VIOL_COUNT_W = 16;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

    // Adds 0..2 completions to the violation count, clamping at all-ones.
    function automatic logic [VIOL_COUNT_W-1:0] sat_add(
        input logic [VIOL_COUNT_W-1:0] base,
        input logic [1:0]              inc
    );
        logic [VIOL_COUNT_W:0] sum;
        sum = {1'b0, base} + {{(VIOL_COUNT_W-1){1'b0}}, inc};
        return sum[VIOL_COUNT_W] ? {VIOL_COUNT_W{1'b1}} : sum[VIOL_COUNT_W-1:0];
    endfunction

endpackage

// File: rtl/axi_deny_responder_if.sv
// AXI4 slave-side signal bundle for the deny responder; WDATA/WSTRB are
// deliberately absent because denied write data is discarded.
interface axi_deny_responder_if #(
    parameter int ID_W   = 1,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic              awvalid;
    logic              awready;

    logic              wlast;
    logic              wvalid;
    logic              wready;

    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic              arvalid;
    logic              arready;

    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport master (
        output awid, awaddr, awlen, awvalid, input awready,
        output wlast, wvalid, input wready,
        input  bid, bresp, bvalid, output bready,
        output arid, araddr, arlen, arvalid, input arready,
        input  rid, rdata, rresp, rlast, rvalid, output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awvalid, output awready,
        input  wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready,
        input  arid, araddr, arlen, arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid, input rready
    );

endinterface

// File: rtl/axi_deny_responder.sv
// Sink for AXI4 transactions rejected by the protection unit: completes each
// one with C_DENY_RESP and records violation count, last address and an IRQ.
module axi_deny_responder
    import axi_deny_responder_pkg::*;
#(
    parameter int         C_S_AXI_ID_WIDTH   = 1,
    parameter int         C_S_AXI_ADDR_WIDTH = 32,
    parameter int         C_S_AXI_DATA_WIDTH = 32,
    parameter logic [1:0] C_DENY_RESP        = RESP_DECERR
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    axi_deny_responder_if.slave           s_axi,
    output logic [VIOL_COUNT_W-1:0]       VIOL_COUNT,
    output logic [C_S_AXI_ADDR_WIDTH-1:0] VIOL_ADDR,
    output logic                          VIOL_IRQ,
    input  logic                          VIOL_CLEAR
);

    w_state_e w_state_q, w_state_d;
    r_state_e r_state_q, r_state_d;

    logic                          ready_en_q, ready_en_d;
    logic [C_S_AXI_ID_WIDTH-1:0]   bid_q, bid_d;
    logic [C_S_AXI_ID_WIDTH-1:0]   rid_q, rid_d;
    logic [7:0]                    beat_cnt_q, beat_cnt_d;
    logic [VIOL_COUNT_W-1:0]       viol_count_q, viol_count_d;
    logic [C_S_AXI_ADDR_WIDTH-1:0] viol_addr_q, viol_addr_d;
    logic                          viol_irq_q, viol_irq_d;

    logic       aw_hs, w_last_hs, b_hs, ar_hs, r_hs, r_last_hs;
    logic [1:0] viol_inc;
    logic       unused_awlen;

    // Beat counts are never checked against AWLEN; only WLAST ends the burst.
    assign unused_awlen = ^s_axi.awlen;

    assign aw_hs     = s_axi.awvalid & s_axi.awready;
    assign w_last_hs = s_axi.wvalid & s_axi.wready & s_axi.wlast;
    assign b_hs      = s_axi.bvalid & s_axi.bready;
    assign ar_hs     = s_axi.arvalid & s_axi.arready;
    assign r_hs      = s_axi.rvalid & s_axi.rready;
    assign r_last_hs = r_hs & s_axi.rlast;

    // NOTE: all state updates use non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, regardless of block order.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            w_state_q    <= W_IDLE;
            r_state_q    <= R_IDLE;
            ready_en_q   <= 1'b0;
            bid_q        <= '0;
            rid_q        <= '0;
            beat_cnt_q   <= '0;
            viol_count_q <= '0;
            viol_addr_q  <= '0;
            viol_irq_q   <= 1'b0;
        end else begin
            w_state_q    <= w_state_d;
            r_state_q    <= r_state_d;
            ready_en_q   <= ready_en_d;
            bid_q        <= bid_d;
            rid_q        <= rid_d;
            beat_cnt_q   <= beat_cnt_d;
            viol_count_q <= viol_count_d;
            viol_addr_q  <= viol_addr_d;
            viol_irq_q   <= viol_irq_d;
        end
    end

    // NOTE: every comb output is given a default before the case statement so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_d = w_state_q;
        bid_d     = bid_q;
        case (w_state_q)
            W_IDLE: if (aw_hs) begin
                bid_d     = s_axi.awid;
                w_state_d = W_DATA;
            end
            W_DATA: if (w_last_hs) w_state_d = W_RESP;
            W_RESP: if (b_hs)      w_state_d = W_IDLE;
            default:               w_state_d = W_IDLE;
        endcase
    end

    // Ready is held off until the first edge with reset released.
    always_comb begin
        s_axi.awready = 1'b0;
        s_axi.wready  = 1'b0;
        s_axi.bvalid  = 1'b0;
        case (w_state_q)
            W_IDLE:  s_axi.awready = ready_en_q;
            W_DATA:  s_axi.wready  = 1'b1;
            W_RESP:  s_axi.bvalid  = 1'b1;
            default: ;
        endcase
    end

    assign s_axi.bid   = bid_q;
    assign s_axi.bresp = C_DENY_RESP;

    always_comb begin
        r_state_d  = r_state_q;
        rid_d      = rid_q;
        beat_cnt_d = beat_cnt_q;
        case (r_state_q)
            R_IDLE: if (ar_hs) begin
                rid_d      = s_axi.arid;
                beat_cnt_d = s_axi.arlen;
                r_state_d  = R_DATA;
            end
            R_DATA: if (r_hs) begin
                if (beat_cnt_q == 8'd0) r_state_d  = R_IDLE;
                else                    beat_cnt_d = beat_cnt_q - 8'd1;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        s_axi.arready = 1'b0;
        s_axi.rvalid  = 1'b0;
        case (r_state_q)
            R_IDLE:  s_axi.arready = ready_en_q;
            R_DATA:  s_axi.rvalid  = 1'b1;
            default: ;
        endcase
    end

    assign s_axi.rid   = rid_q;
    assign s_axi.rdata = '0;
    assign s_axi.rresp = C_DENY_RESP;
    assign s_axi.rlast = (beat_cnt_q == 8'd0);

    // A clear coinciding with completions leaves exactly those completions counted.
    assign viol_inc = {1'b0, b_hs} + {1'b0, r_last_hs};

    always_comb begin
        ready_en_d   = 1'b1;
        viol_count_d = sat_add(VIOL_CLEAR ? '0 : viol_count_q, viol_inc);
        viol_irq_d   = (viol_inc != 2'd0) | (viol_irq_q & ~VIOL_CLEAR);
        viol_addr_d  = viol_addr_q;
        if (aw_hs)      viol_addr_d = s_axi.awaddr;
        else if (ar_hs) viol_addr_d = s_axi.araddr;
    end

    assign VIOL_COUNT = viol_count_q;
    assign VIOL_ADDR  = viol_addr_q;
    assign VIOL_IRQ   = viol_irq_q;

endmodule

// File: tb/tb_axi_deny_responder.sv
// Scoreboard bench for axi_deny_responder: expected B/R responses are queued
// as commands are issued and checked as the DUT hands them over.
module tb_axi_deny_responder;
    import axi_deny_responder_pkg::*;

    localparam int ID_W   = 1;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef struct {
        logic [ID_W-1:0] id;
        logic            last;
    } r_beat_t;

    logic              aclk;
    logic              aresetn;
    logic              viol_clear;
    logic [15:0]       viol_count;
    logic [ADDR_W-1:0] viol_addr;
    logic              viol_irq;

    int checks;
    int errors;
    int done_count;
    int base;

    logic [ID_W-1:0] b_exp_q[$];
    r_beat_t         r_exp_q[$];
    logic [ID_W-1:0] b_e;
    r_beat_t         r_e;

    axi_deny_responder_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) s_axi ();

    axi_deny_responder #(
        .C_S_AXI_ID_WIDTH  (ID_W),
        .C_S_AXI_ADDR_WIDTH(ADDR_W),
        .C_S_AXI_DATA_WIDTH(DATA_W),
        .C_DENY_RESP       (RESP_DECERR)
    ) dut (
        .ACLK      (aclk),
        .ARESETN   (aresetn),
        .s_axi     (s_axi),
        .VIOL_COUNT(viol_count),
        .VIOL_ADDR (viol_addr),
        .VIOL_IRQ  (viol_irq),
        .VIOL_CLEAR(viol_clear)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #300000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Responses are sampled mid-cycle; a handshake seen here completes at the next edge.
    always @(negedge aclk) begin
        if (aresetn && s_axi.bvalid && s_axi.bready) begin
            if (b_exp_q.size() == 0) begin
                check("b_unexpected", 64'd1, 64'd0);
            end else begin
                b_e = b_exp_q.pop_front();
                check("bid", s_axi.bid, b_e);
                check("bresp", s_axi.bresp, RESP_DECERR);
                done_count++;
            end
        end
        if (aresetn && s_axi.rvalid && s_axi.rready) begin
            if (r_exp_q.size() == 0) begin
                check("r_unexpected", 64'd1, 64'd0);
            end else begin
                r_e = r_exp_q.pop_front();
                check("rid", s_axi.rid, r_e.id);
                check("rlast", s_axi.rlast, r_e.last);
                check("rdata", s_axi.rdata, 64'd0);
                check("rresp", s_axi.rresp, RESP_DECERR);
                if (r_e.last) done_count++;
            end
        end
    end

    task automatic idle_bus();
        s_axi.awid = '0; s_axi.awaddr = '0; s_axi.awlen = '0; s_axi.awvalid = 1'b0;
        s_axi.wlast = 1'b0; s_axi.wvalid = 1'b0; s_axi.bready = 1'b1;
        s_axi.arid = '0; s_axi.araddr = '0; s_axi.arlen = '0; s_axi.arvalid = 1'b0;
        s_axi.rready = 1'b1;
    endtask

    // All driver tasks are entered and left just after a rising edge.
    task automatic send_aw(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                           input logic [7:0] len);
        int n;
        s_axi.awid = id; s_axi.awaddr = addr; s_axi.awlen = len; s_axi.awvalid = 1'b1;
        n = 0;
        do begin @(negedge aclk); n++; end while (!s_axi.awready && n < 50);
        check("aw_hs", s_axi.awready, 1'b1);
        @(posedge aclk); #1;
        s_axi.awvalid = 1'b0;
    endtask

    task automatic send_w(input int beats);
        int n;
        for (int i = 0; i < beats; i++) begin
            s_axi.wvalid = 1'b1;
            s_axi.wlast  = (i == beats - 1);
            n = 0;
            do begin @(negedge aclk); n++; end while (!s_axi.wready && n < 50);
            check("w_hs", s_axi.wready, 1'b1);
            @(posedge aclk); #1;
        end
        s_axi.wvalid = 1'b0;
        s_axi.wlast  = 1'b0;
    endtask

    task automatic send_ar(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                           input logic [7:0] len);
        int n;
        s_axi.arid = id; s_axi.araddr = addr; s_axi.arlen = len; s_axi.arvalid = 1'b1;
        n = 0;
        do begin @(negedge aclk); n++; end while (!s_axi.arready && n < 50);
        check("ar_hs", s_axi.arready, 1'b1);
        @(posedge aclk); #1;
        s_axi.arvalid = 1'b0;
    endtask

    task automatic do_write(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                            input logic [7:0] len);
        b_exp_q.push_back(id);
        send_aw(id, addr, len);
        send_w(int'(len) + 1);
    endtask

    task automatic do_read(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                           input logic [7:0] len);
        r_beat_t beat;
        for (int i = 0; i <= int'(len); i++) begin
            beat.id   = id;
            beat.last = (i == int'(len));
            r_exp_q.push_back(beat);
        end
        send_ar(id, addr, len);
    endtask

    task automatic wait_b_done();
        for (int n = 0; n < 100 && b_exp_q.size() != 0; n++) @(posedge aclk);
        #1;
        check("b_drain", b_exp_q.size(), 0);
    endtask

    task automatic wait_r_done();
        for (int n = 0; n < 200 && r_exp_q.size() != 0; n++) @(posedge aclk);
        #1;
        check("r_drain", r_exp_q.size(), 0);
    endtask

    initial begin
        checks = 0; errors = 0; done_count = 0; base = 0;
        aresetn = 1'b0; viol_clear = 1'b0;
        idle_bus();
        repeat (3) @(posedge aclk);
        #1;

        // Reset state, then ready rises one edge after release.
        check("rst_awready", s_axi.awready, 1'b0);
        check("rst_arready", s_axi.arready, 1'b0);
        check("rst_wready", s_axi.wready, 1'b0);
        check("rst_bvalid", s_axi.bvalid, 1'b0);
        check("rst_rvalid", s_axi.rvalid, 1'b0);
        check("rst_count", viol_count, 16'd0);
        check("rst_addr", viol_addr, 32'd0);
        check("rst_irq", viol_irq, 1'b0);
        aresetn = 1'b1;
        @(posedge aclk); #1;
        check("rel_awready", s_axi.awready, 1'b1);
        check("rel_arready", s_axi.arready, 1'b1);

        // Eight-beat denied write.
        do_write(1'b1, 32'h4000_0010, 8'd7);
        wait_b_done();
        check("w8_count", viol_count, 16'd1);
        check("w8_addr", viol_addr, 32'h4000_0010);
        check("w8_irq", viol_irq, 1'b1);

        // Minimum write latency: WLAST waiting alongside AW.
        b_exp_q.push_back(1'b0);
        s_axi.awid = 1'b0; s_axi.awaddr = 32'h4000_0100; s_axi.awlen = 8'd0;
        s_axi.awvalid = 1'b1; s_axi.wvalid = 1'b1; s_axi.wlast = 1'b1;
        @(posedge aclk); #1;
        s_axi.awvalid = 1'b0;
        check("lat_b_early", s_axi.bvalid, 1'b0);
        check("lat_wready", s_axi.wready, 1'b1);
        @(posedge aclk); #1;
        s_axi.wvalid = 1'b0; s_axi.wlast = 1'b0;
        check("lat_b", s_axi.bvalid, 1'b1);
        wait_b_done();
        check("lat_w_count", viol_count, 16'd2);

        // Minimum read latency.
        r_e.id = 1'b0; r_e.last = 1'b1;
        r_exp_q.push_back(r_e);
        s_axi.arid = 1'b0; s_axi.araddr = 32'h4000_0200; s_axi.arlen = 8'd0; s_axi.arvalid = 1'b1;
        @(posedge aclk); #1;
        s_axi.arvalid = 1'b0;
        check("lat_r", s_axi.rvalid, 1'b1);
        wait_r_done();
        check("lat_r_addr", viol_addr, 32'h4000_0200);

        // Four-beat read with RREADY toggling.
        do_read(1'b1, 32'h4000_0300, 8'd3);
        for (int n = 0; n < 100 && r_exp_q.size() != 0; n++) begin
            @(posedge aclk); #1;
            s_axi.rready = ~s_axi.rready;
        end
        s_axi.rready = 1'b1;
        wait_r_done();
        check("r4_count", viol_count, 16'd4);
        check("r4_addr", viol_addr, 32'h4000_0300);

        // Simultaneous AW and AR handshakes.
        fork
            do_write(1'b0, 32'h5000_0000, 8'd0);
            do_read(1'b1, 32'h6000_0000, 8'd0);
        join
        wait_b_done();
        wait_r_done();
        check("both_count", viol_count, 16'd6);
        check("both_addr", viol_addr, 32'h5000_0000);
        check("both_model", viol_count, 16'(done_count - base));

        // Back-pressured write response stays stable and blocks new AW.
        s_axi.bready = 1'b0;
        do_write(1'b1, 32'h7000_0000, 8'd2);
        for (int i = 0; i < 10; i++) begin
            check("hold_bvalid", s_axi.bvalid, 1'b1);
            check("hold_bid", s_axi.bid, 1'b1);
            check("hold_bresp", s_axi.bresp, RESP_DECERR);
            check("hold_awready", s_axi.awready, 1'b0);
            @(posedge aclk); #1;
        end
        s_axi.bready = 1'b1;
        wait_b_done();
        check("hold_count", viol_count, 16'd7);

        // Clear coincident with a B handshake, then a lone clear.
        s_axi.bready = 1'b0;
        do_write(1'b0, 32'h7000_0100, 8'd1);
        s_axi.bready = 1'b1;
        viol_clear = 1'b1;
        @(posedge aclk); #1;
        viol_clear = 1'b0;
        check("clr_b_count", viol_count, 16'd1);
        check("clr_b_irq", viol_irq, 1'b1);
        base = done_count - 1;
        viol_clear = 1'b1;
        @(posedge aclk); #1;
        viol_clear = 1'b0;
        check("clr_count", viol_count, 16'd0);
        check("clr_irq", viol_irq, 1'b0);
        base = done_count;

        // Reset during beat 2 of an 8-beat read abandons it.
        do_read(1'b0, 32'h8000_0000, 8'd7);
        for (int n = 0; n < 20 && r_exp_q.size() != 7; n++) begin
            @(posedge aclk); #1;
        end
        check("mid_beat2", r_exp_q.size(), 7);
        aresetn = 1'b0;
        @(posedge aclk); #1;
        check("mid_rvalid", s_axi.rvalid, 1'b0);
        check("mid_count", viol_count, 16'd0);
        check("mid_addr", viol_addr, 32'd0);
        check("mid_arready", s_axi.arready, 1'b0);
        r_exp_q.delete();
        base = done_count;
        aresetn = 1'b1;
        @(posedge aclk); #1;
        check("mid_rel_arready", s_axi.arready, 1'b1);
        do_read(1'b1, 32'h9000_0000, 8'd0);
        wait_r_done();
        check("post_rst_count", viol_count, 16'(done_count - base));
        check("post_rst_one", viol_count, 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
